// File: rtl/pong_scoreboard.sv
// Two-player BCD score keeper with win detection and a multiplexed
// common-anode seven-segment scanner (leading-zero blanking, game-over blink).
module pong_scoreboard #(
    parameter int DPP          = 2,
    parameter int SCAN_DIV     = 50000,
    parameter int WIN_SCORE    = 11,
    parameter int BLINK_FRAMES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lose1,
    input  logic             lose2,
    input  logic             clr_score,
    output logic [2*DPP-1:0] select,
    output logic [6:0]       seg,
    output logic             game_over,
    output logic [1:0]       winner
);
    localparam int D  = 2 * DPP;
    localparam int SW = 4 * DPP;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    function automatic logic [SW-1:0] to_bcd(input int n);
        logic [SW-1:0] r;
        int            m;
        r = '0;
        m = n;
        for (int i = 0; i < DPP; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DPP; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    localparam logic [SW-1:0] WIN_BCD    = to_bcd(WIN_SCORE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(D - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // Bit 0 tracks player 1's lose line, bit 1 player 2's.
    logic [1:0]    l_q, l_qq, ev_q;
    logic [SW-1:0] score1, score2, next1, next2;
    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [FW-1:0] frame;
    logic          blink, blink_tog;
    logic [SW-1:0] field;
    logic [3:0]    digit;
    logic          blank, win_field;
    int            pos;
    logic [D-1:0]  sel_next;
    logic [6:0]    seg_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            l_q  <= 2'b00;
            l_qq <= 2'b00;
            ev_q <= 2'b00;
        end else begin
            l_q  <= {lose2, lose1};
            l_qq <= l_q;
            ev_q <= l_q & ~l_qq;
        end
    end

    assign next1 = bcd_inc(score1);
    assign next2 = bcd_inc(score2);

    // A simultaneous double miss (ev_q == 2'b11) scores for nobody.
    always_ff @(posedge clk) begin
        if (!rst) begin
            score1    <= '0;
            score2    <= '0;
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else if (clr_score) begin
            score1    <= '0;
            score2    <= '0;
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else if (!game_over) begin
            if (ev_q == 2'b01) begin
                score2 <= next2;
                if (next2 == WIN_BCD) begin
                    game_over <= 1'b1;
                    winner    <= 2'b10;
                end
            end else if (ev_q == 2'b10) begin
                score1 <= next1;
                if (next1 == WIN_BCD) begin
                    game_over <= 1'b1;
                    winner    <= 2'b01;
                end
            end
        end
    end

    assign blink_tog = (presc == PRESC_LAST) && (idx == IDX_LAST) && (frame == FRAME_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
            frame <= '0;
            blink <= 1'b0;
        end else begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                if (idx == IDX_LAST) begin
                    idx   <= '0;
                    frame <= (frame == FRAME_LAST) ? '0 : frame + FW'(1);
                end else begin
                    idx <= idx + IW'(1);
                end
            end else begin
                presc <= presc + PW'(1);
            end
            if (clr_score)
                blink <= 1'b0;
            else if (blink_tog)
                blink <= ~blink;
        end
    end

    always_comb begin
        field     = score1;
        win_field = winner[0];
        pos       = int'(idx);
        if (int'(idx) >= DPP) begin
            field     = score2;
            win_field = winner[1];
            pos       = int'(idx) - DPP;
        end
        digit = field[pos*4 +: 4];
        // A non-units digit is dark when it and everything above it is zero.
        blank = (pos != 0) && ((field >> (4 * pos)) == '0);
        if (game_over && blink && win_field)
            blank = 1'b1;
        sel_next = ~(D'(1) << idx);
        seg_next = blank ? 7'h7F : seg_decode(digit);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            select <= '1;
            seg    <= 7'h7F;
        end else begin
            select <= sel_next;
            seg    <= seg_next;
        end
    end
endmodule

// File: tb/tb_pong_scoreboard.sv
// Bench for pong_scoreboard: vector table for reset/scan, directed game
// sequences and randomized play against an arithmetic reference model.
module tb_pong_scoreboard;
    localparam int DPP = 2, SD = 4, WIN = 11, BF = 2, D = 2 * DPP;

    logic         clk = 1'b0, rst = 1'b0, lose1 = 1'b0, lose2 = 1'b0, clr_score = 1'b0;
    logic [D-1:0] select;
    logic [6:0]   seg;
    logic         game_over;
    logic [1:0]   winner;

    int checks = 0, errors = 0;

    // Reference model state: integer scores, edge index since reset release.
    int n = 0, m_s1 = 0, m_s2 = 0, m_win = 0;
    bit m_go = 0, m_phase = 0;
    int h1[3] = '{0, 0, 0};
    int h2[3] = '{0, 0, 0};
    int seg_code[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

    typedef struct {
        bit r, c, l1, l2;
        int sel, sg, go, win;
    } vec_t;
    vec_t tbl[19];

    always #5 clk = ~clk;

    pong_scoreboard #(.DPP(DPP), .SCAN_DIV(SD), .WIN_SCORE(WIN), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .lose1(lose1), .lose2(lose2), .clr_score(clr_score),
        .select(select), .seg(seg), .game_over(game_over), .winner(winner)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic int exp_seg(input int idx);
        int field, pos, p10;
        bit winf;
        field = (idx < DPP) ? m_s1 : m_s2;
        pos   = idx % DPP;
        winf  = (idx < DPP) ? (m_win == 1) : (m_win == 2);
        p10   = 1;
        for (int i = 0; i < pos; i++) p10 *= 10;
        if (m_go && m_phase && winf) return 'h7F;
        if (pos > 0 && field < p10) return 'h7F;
        return seg_code[(field / p10) % 10];
    endfunction

    task automatic step(input bit r, input bit c, input bit l1, input bit l2);
        int  e_sel, e_seg, idx;
        bit  ev1, ev2;
        rst = r; clr_score = c; lose1 = l1; lose2 = l2;
        @(posedge clk);
        if (!r) begin
            n = 0; m_s1 = 0; m_s2 = 0; m_go = 0; m_win = 0; m_phase = 0;
            h1 = '{0, 0, 0}; h2 = '{0, 0, 0};
            e_sel = 'hF; e_seg = 'h7F;
        end else begin
            idx   = (n / SD) % D;
            e_sel = (~(1 << idx)) & 'hF;
            e_seg = exp_seg(idx);
            ev1 = (h1[1] != 0) && (h1[2] == 0);
            ev2 = (h2[1] != 0) && (h2[2] == 0);
            if (c) begin
                m_s1 = 0; m_s2 = 0; m_go = 0; m_win = 0; m_phase = 0;
            end else begin
                if (!m_go && ev1 && !ev2) begin
                    m_s2++;
                    if (m_s2 == WIN) begin m_go = 1; m_win = 2; end
                end else if (!m_go && ev2 && !ev1) begin
                    m_s1++;
                    if (m_s1 == WIN) begin m_go = 1; m_win = 1; end
                end
                if ((n + 1) % (SD * D * BF) == 0) m_phase = !m_phase;
            end
            h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = l1;
            h2[2] = h2[1]; h2[1] = h2[0]; h2[0] = l2;
            n++;
        end
        @(negedge clk);
        chk("select", int'(select), e_sel);
        chk("seg", int'(seg), e_seg);
        chk("game_over", int'(game_over), int'(m_go));
        chk("winner", int'(winner), m_win);
    endtask

    task automatic pulse(input int which);
        step(1, 0, which == 1, which == 2);
        step(1, 0, which == 1, which == 2);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    task automatic check_slot(input string name, input int idx, input int exp);
        bit found;
        found = 0;
        for (int k = 0; k < 2 * D * SD && !found; k++) begin
            step(1, 0, 0, 0);
            if (int'(select) == ((~(1 << idx)) & 'hF)) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: slot %0d never selected, select=%0h", name, idx, select);
        end else begin
            chk(name, int'(seg), exp);
        end
    endtask

    initial begin
        int lit, dark, p1_lit;
        bit l1r, l2r, rr, cr;

        for (int i = 0; i < 3; i++) tbl[i] = '{0, 0, 0, 0, 'hF, 'h7F, 0, 0};
        for (int i = 0; i < 16; i++) begin
            tbl[3+i] = '{1, 0, 0, 0, (~(1 << (i / SD))) & 'hF,
                         ((i / SD) == 0 || (i / SD) == 2) ? 'h40 : 'h7F, 0, 0};
        end

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].c, tbl[i].l1, tbl[i].l2);
            chk("tbl_select", int'(select), tbl[i].sel);
            chk("tbl_seg", int'(seg), tbl[i].sg);
            chk("tbl_game_over", int'(game_over), tbl[i].go);
            chk("tbl_winner", int'(winner), tbl[i].win);
        end

        // Long lose1 level: exactly one point for player 2.
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        check_slot("single_p2_units", 2, 'h79);
        check_slot("single_p2_tens", 3, 'h7F);

        // Ten points for player 1 exercises the BCD carry.
        for (int i = 0; i < 10; i++) pulse(2);
        check_slot("carry_p1_tens", 1, 'h79);
        check_slot("carry_p1_units", 0, 'h40);

        // Double miss scores nothing.
        step(1, 0, 1, 1);
        step(1, 0, 1, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_slot("simul_p1_units", 0, 'h40);
        check_slot("simul_p2_units", 2, 'h79);

        // Clear lands on the same edge as a pending score update.
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        chk("clr_game_over", int'(game_over), 0);
        chk("clr_winner", int'(winner), 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_slot("clr_p1_units", 0, 'h40);
        check_slot("clr_p1_tens", 1, 'h7F);
        check_slot("clr_p2_units", 2, 'h40);

        // Player 2 reaches the win score; a further edge is ignored.
        for (int i = 0; i < WIN; i++) pulse(1);
        chk("win_game_over", int'(game_over), 1);
        chk("win_winner", int'(winner), 2);
        pulse(1);
        lit = 0; dark = 0; p1_lit = 0;
        for (int i = 0; i < 128; i++) begin
            step(1, 0, 0, 0);
            if (select[3] == 1'b0 || select[2] == 1'b0) begin
                if (seg == 7'h79) lit++;
                else if (seg == 7'h7F) dark++;
            end
            if (select[0] == 1'b0 && seg == 7'h40) p1_lit++;
        end
        chk("blink_p2_lit", lit, 32);
        chk("blink_p2_dark", dark, 32);
        chk("blink_p1_lit", p1_lit, 32);
        chk("after_win_game_over", int'(game_over), 1);
        step(1, 1, 0, 0);
        chk("clr2_game_over", int'(game_over), 0);
        chk("clr2_winner", int'(winner), 0);

        // Randomized play with occasional clears and resets.
        l1r = 0; l2r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) l1r = !l1r;
            if ($urandom_range(0, 5) == 0) l2r = !l2r;
            rr = ($urandom_range(0, 599) != 0);
            cr = ($urandom_range(0, 249) == 0);
            step(rr, cr, l1r, l2r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pong_scoreboard.md
# pong_scoreboard

Parametrised two-player score keeper and multiplexed seven-segment driver for the pong game. Sits beside the VGA display block, consumes its per-player `lose` pulses, keeps BCD scores, detects a win and scans the scores onto a common-anode display. Supersedes the fixed 4-digit `seven_seg` stub: digit count, scan rate, win score and blink rate are parameters. Adds leading-zero blanking, game-over blink and a score clear.

## Interface
- `DPP`, 2: BCD digits per player; total digits D = 2*DPP.
- `SCAN_DIV`, 50000: clocks per digit slot; must be ≥ 2.
- `WIN_SCORE`, 11: score that ends the game; 1 ≤ WIN_SCORE ≤ 10^DPP − 1.
- `BLINK_FRAMES`, 64: full scan frames (D slots each) per blink half-period.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `lose1`  in  1  level from VGA block; rising edge = player 1 missed, player 2 scores.
- `lose2`  in  1  rising edge = player 2 missed, player 1 scores.
- `clr_score`  in  1  synchronous clear of scores and game state, active-high.
- `select`  out  D  digit anodes, one-hot active-low; bit 0 = rightmost.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `game_over`  out  1  high once a player reaches WIN_SCORE.
- `winner`  out  2  01 = player 1, 10 = player 2, 00 = none.

## Operation
- Input stage: `lose1`/`lose2` registered once (`l_q`), then again (`l_qq`); event = `l_q & ~l_qq`. One event per rising edge regardless of level width.
- Scoring: event1 → score2 += 1; event2 → score1 += 1. Both events in same cycle → neither scores (double miss).
- BCD increment: digit 9 → 0 with carry into next digit; width DPP×4 bits per player. No wrap past WIN_SCORE is possible (see below).
- Win: when a score update makes a player's score equal WIN_SCORE, `game_over`←1 and `winner` set in the same clock as the score update. While `game_over`=1, all events are ignored; scores frozen.
- Priority per clock: `rst` low > `clr_score` > events.
- `clr_score`: scores←0, `game_over`←0, `winner`←00, blink phase←0, edge-detect registers untouched. Prescaler and scan keep running.
- Scan: prescaler counts 0..SCAN_DIV−1; at terminal count the digit index advances 0..D−1, wrapping D−1→0. The frame counter increments on each wrap to 0. At BLINK_FRAMES−1 it resets to 0 and blink phase toggles.
- Digit map: indices 0..DPP−1 = player 1 (index 0 = units), DPP..D−1 = player 2 (index DPP = units).
- Leading-zero blanking: within each player field, a non-units digit is blanked (`seg`=7'h7F) if it and all higher digits of that field are 0. Units digit is always shown.
- Game-over blink: while `game_over`=1 and blink phase=1, the winner's digits are blanked; the loser's digits stay lit.
- Segment decode for digits 0–9 is the standard common-anode code, e.g. 0→7'h40, 1→7'h79, 8→7'h00.

## Timing
- Reset values: `select` = all ones, `seg` = 7'h7F, `game_over`=0, `winner`=00. Scores, prescaler, digit index, frame counter and blink phase are all 0.
- Score latency: `lose` first sampled high at edge k → score, `game_over` and `winner` registered at edge k+2.
- `select` and `seg` are registered outputs. They reflect digit index i and the current scores one clock after index i is entered, and change together, never separately.
- First display after reset release: `select`=~1 (bit 0 low) at the first edge with `rst` high.
- Each digit is active for exactly SCAN_DIV clocks; frame = D×SCAN_DIV clocks.
- A score change mid-slot appears on `seg` on the next clock, within the same slot.
- `rst` low mid-frame: all state returns to reset values at that edge; a pending edge event is lost.

## Test plan
- Reset/scan (DPP=2, SCAN_DIV=4): hold `rst`=0 for 3 clocks, then release → `select` cycles 1110,1101,1011,0111, each held 4 clocks. `seg`=7'h40 on bits 0 and 2; other slots show 7'h7F (blanked zeros).
- Single point: pulse `lose1` high for 10 clocks → score2 = 01 exactly once, 2 clocks after first sample. Slot 2 shows 7'h79.
- Carry/blanking: 10 separate `lose2` edges → score1 = BCD 10. Slot 1 shows 7'h79, slot 0 shows 7'h40.
- Simultaneous: `lose1` and `lose2` rise in the same clock → both scores unchanged.
- Win/blink (WIN_SCORE=11, BLINK_FRAMES=2): 11 `lose1` edges → `game_over`=1, `winner`=10. A 12th edge leaves score2=11. Player 2 digits blank on alternate 2-frame periods; player 1 digits stay lit.
- Clear: `clr_score` pulse while an event arrives in the same clock → scores 0, `game_over`=0, `winner`=00. The event is discarded and the scan index is undisturbed.
